// File: rtl/bitwise_logic_pkg.sv
// Shared definitions for the bitwise logic unit: op encoding, legal
// parameter ranges and the single-bit evaluation function.
package bitwise_logic_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NOR    = 3'd3,
    OP_ANDN   = 3'd4,
    OP_NOT_A  = 3'd5,
    OP_PASS_A = 3'd6,
    OP_PASS_B = 3'd7
  } op_e;

  localparam int STAGES_MIN    = 1;
  localparam int STAGES_MAX    = 4;
  localparam int DATA_SIZE_MIN = 1;
  localparam int DATA_SIZE_MAX = 64;

  // One result bit depends only on the matching operand bits and op.
  function automatic logic blu_bit(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOR:    r = ~(a | b);
      OP_ANDN:   r = a & ~b;
      OP_NOT_A:  r = ~a;
      OP_PASS_A: r = a;
      OP_PASS_B: r = b;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/blu_stage.sv
// One pipeline register: valid bit plus payload (result, and flags when
// enabled). Loads from upstream when told to advance, otherwise holds.
module blu_stage
  import bitwise_logic_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         adv,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         vld,
  output logic [W-1:0] data
);

  logic         vld_d, vld_q;
  logic [W-1:0] data_d, data_q;

  // Next state: take upstream on advance; payload only moves with a valid
  // entry so bubbles do not toggle the data register.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv) begin
      vld_d = in_vld;
      if (in_vld) data_d = in_data;
    end
  end

  // State register, cleared asynchronously so nothing stale survives reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign data = data_q;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit with valid/ready handshake on both sides.
// The op is evaluated combinationally up front; STAGES blu_stage registers
// carry the result (and flags) with per-stage bubble-collapsing advance.
// Optional feature macro: BITWISE_LOGIC_FLAGS_EN enables zero/negative flags;
// without it both flags are tied low and no flag registers exist.
module bitwise_logic_unit
  import bitwise_logic_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] result,
  output logic                 zero,
  output logic                 negative
);

`ifdef BITWISE_LOGIC_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif
  localparam int PW = DATA_SIZE + FLAG_W;

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("bitwise_logic_unit: STAGES out of range");
  end
  if (DATA_SIZE < DATA_SIZE_MIN || DATA_SIZE > DATA_SIZE_MAX) begin : g_bad_width
    $error("bitwise_logic_unit: DATA_SIZE out of range");
  end

  logic [DATA_SIZE-1:0]     res_c;
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][PW-1:0]  pay;
  logic [STAGES-1:0]        adv;
  logic                     ready_en_d, ready_en_q;

  // Per-bit evaluation; bit i sees only a[i], b[i] and op.
  for (genvar i = 0; i < DATA_SIZE; i++) begin : g_bit
    assign res_c[i] = blu_bit(op_e'(op), a[i], b[i]);
  end

`ifdef BITWISE_LOGIC_FLAGS_EN
  assign pay[0]   = {res_c[DATA_SIZE-1], ~|res_c, res_c};
  assign zero     = pay[STAGES][DATA_SIZE];
  assign negative = pay[STAGES][DATA_SIZE+1];
`else
  assign pay[0]   = res_c;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

  // Advance chain from the output backwards: a stage moves when it is empty
  // or everything downstream of it moves. Only out_ready enters combinationally.
  always_comb begin
    logic a_l;
    adv = '0;
    a_l = ~vld_pipe[STAGES] | out_ready;
    adv[STAGES-1] = a_l;
    for (int k = STAGES - 2; k >= 0; k--) begin
      a_l    = ~vld_pipe[k+1] | a_l;
      adv[k] = a_l;
    end
  end

  // Ready gate comes up on the first edge after reset release.
  always_comb begin
    ready_en_d = 1'b1;
  end

  // Ready-gate register, held low throughout reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en_q <= 1'b0;
    else          ready_en_q <= ready_en_d;
  end

  assign in_ready    = ready_en_q & adv[0];
  assign vld_pipe[0] = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    blu_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .adv     (adv[k]),
      .in_vld  (vld_pipe[k]),
      .in_data (pay[k]),
      .vld     (vld_pipe[k+1]),
      .data    (pay[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign result    = pay[STAGES][DATA_SIZE-1:0];

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit (DATA_SIZE=64, STAGES=2).
// Expected values come from a word-level reference and an in-order queue.
module tb_bitwise_logic_unit;

  localparam int DS = 64;
  localparam int ST = 2;
`ifdef BITWISE_LOGIC_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = '0;
  logic [DS-1:0] a = '0;
  logic [DS-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DS-1:0] result;
  logic          zero;
  logic          negative;

  int total = 0;
  int bad   = 0;
  logic [DS+1:0] exp_q[$];

  always #5 clk = ~clk;

  bitwise_logic_unit #(.DATA_SIZE(DS), .STAGES(ST)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative)
  );

  // Word-level reference: {negative, zero, result}
  function automatic logic [DS+1:0] ref_full(input logic [2:0] o, input logic [DS-1:0] x, input logic [DS-1:0] y);
    logic [DS-1:0] r;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x | y);
      3'd4: r = x & ~y;
      3'd5: r = ~x;
      3'd6: r = x;
      default: r = y;
    endcase
    return {FE && r[DS-1], FE && (r == '0), r};
  endfunction

  function automatic logic [DS-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one op with out_ready high; report what came out and after how many edges.
  task automatic run_single(input logic [2:0] o, input logic [DS-1:0] x, input logic [DS-1:0] y,
                            output logic [DS+1:0] got, output int lat);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step(); #1; lat++;
    end
    got = {negative, zero, result};
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    total++; if ({zero, negative} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {zero, negative}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    reset_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready_pre_edge: got %b want 0", in_ready); end
    step(); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready_post_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_and();
    logic [DS+1:0] got;
    int lat;
    run_single(3'd0, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, got, lat);
    total++; if (lat !== ST) begin bad++; $display("FAIL and_latency: got %0d want %0d", lat, ST); end
    total++; if (got[DS-1:0] !== 64'h0F00_0F00_0F00_0F00) begin bad++; $display("FAIL and_result: got %h want 0f000f000f000f00", got[DS-1:0]); end
    total++; if (got[DS+1:DS] !== 2'b00) begin bad++; $display("FAIL and_flags: got %b want 00", got[DS+1:DS]); end
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL and_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_flags();
    logic [DS+1:0] got;
    int lat;
    logic [DS-1:0] rb;
    run_single(3'd2, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, got, lat);
    total++; if (got !== {1'b0, FE, {DS{1'b0}}}) begin bad++; $display("FAIL xor_zero: got %h want %h", got, {1'b0, FE, {DS{1'b0}}}); end
    rb = rnd64();
    run_single(3'd5, '0, rb, got, lat);
    total++; if (got !== {FE, 1'b0, {DS{1'b1}}}) begin bad++; $display("FAIL not_a_neg: got %h want %h", got, {FE, 1'b0, {DS{1'b1}}}); end
    run_single(3'd3, '0, '0, got, lat);
    total++; if (got !== {FE, 1'b0, {DS{1'b1}}}) begin bad++; $display("FAIL nor_zero_ops: got %h want %h", got, {FE, 1'b0, {DS{1'b1}}}); end
    for (int o = 0; o < 8; o++) begin
      logic [DS-1:0] x, y;
      x = rnd64(); y = rnd64();
      run_single(o[2:0], x, y, got, lat);
      total++; if (got !== ref_full(o[2:0], x, y)) begin bad++; $display("FAIL op%0d_random: got %h want %h", o, got, ref_full(o[2:0], x, y)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]    ops[8];
    logic [DS-1:0] as[8], bs[8];
    int n, recv, gaps, cyc;
    for (int i = 0; i < 8; i++) begin
      ops[i] = 3'($urandom_range(0, 7)); as[i] = rnd64(); bs[i] = rnd64();
    end
    exp_q.delete(); n = 0; out_ready = 1'b0;
    for (int c = 0; c < ST + 3; c++) begin
      in_valid = 1'b1; op = ops[n]; a = as[n]; b = bs[n];
      #1;
      if (in_ready) begin exp_q.push_back(ref_full(ops[n], as[n], bs[n])); n++; end
      step();
    end
    #1;
    total++; if (n !== ST) begin bad++; $display("FAIL b2b_accepted_while_stalled: got %0d want %0d", n, ST); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1 || {negative, zero, result} !== exp_q[0]) begin
      bad++; $display("FAIL b2b_stall_hold: got v=%b %h want v=1 %h", out_valid, {negative, zero, result}, exp_q[0]);
    end
    out_ready = 1'b1; recv = 0; gaps = 0; cyc = 0;
    while (recv < 8 && cyc < 50) begin
      in_valid = (n < 8);
      if (n < 8) begin op = ops[n]; a = as[n]; b = bs[n]; end
      #1;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra_output: got %h want none", result); end
        else begin
          logic [DS+1:0] e;
          e = exp_q.pop_front();
          if ({negative, zero, result} !== e) begin bad++; $display("FAIL b2b_order: got %h want %h", {negative, zero, result}, e); end
        end
        recv++;
      end else if (recv > 0) gaps++;
      if (in_valid && in_ready) begin exp_q.push_back(ref_full(ops[n], as[n], bs[n])); n++; end
      step(); cyc++;
    end
    in_valid = 1'b0;
    total++; if (recv !== 8 || n !== 8) begin bad++; $display("FAIL b2b_count: got recv=%0d sent=%0d want 8/8", recv, n); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_full_swap();
    logic [2:0] no; logic [DS-1:0] na, nb;
    int cnt;
    exp_q.delete(); out_ready = 1'b0;
    for (int i = 0; i < ST; i++) begin
      in_valid = 1'b1; op = 3'($urandom_range(0, 7)); a = rnd64(); b = rnd64();
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL swap_fill_ready: got %b want 1", in_ready); end
      exp_q.push_back(ref_full(op, a, b));
      step();
    end
    no = 3'($urandom_range(0, 7)); na = rnd64(); nb = rnd64();
    in_valid = 1'b1; op = no; a = na; b = nb;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL swap_full_blocked: got %b want 0", in_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL swap_ready_follows_out_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b1 || {negative, zero, result} !== exp_q[0]) begin
      bad++; $display("FAIL swap_head: got v=%b %h want v=1 %h", out_valid, {negative, zero, result}, exp_q[0]);
    end
    step();
    void'(exp_q.pop_front());
    exp_q.push_back(ref_full(no, na, nb));
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL swap_still_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    total++; if ({negative, zero, result} !== exp_q[0]) begin bad++; $display("FAIL swap_next_head: got %h want %h", {negative, zero, result}, exp_q[0]); end
    out_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL swap_extra_output: got %h want none", result); end
        else begin
          logic [DS+1:0] e;
          e = exp_q.pop_front();
          if ({negative, zero, result} !== e) begin bad++; $display("FAIL swap_drain: got %h want %h", {negative, zero, result}, e); end
        end
        cnt++;
      end
      step();
    end
    total++; if (cnt !== ST) begin bad++; $display("FAIL swap_drain_count: got %0d want %0d", cnt, ST); end
  endtask

  task automatic test_reset_mid();
    int stale;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op = 3'($urandom_range(0, 7)); a = rnd64(); b = rnd64();
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_setup: got %b want 1", out_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_immediate: got v=%b r=%h rdy=%b want 0/0/0", out_valid, result, in_ready);
    end
    step();
    reset_n = 1'b1; out_ready = 1'b1; exp_q.delete();
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) stale++;
      step();
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL rmid_stale: got %0d want 0", stale); end
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      logic exp_rdy;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? '0 : rnd64();
      b  = ($urandom_range(0, 3) == 0) ? a : rnd64();
      #1;
      exp_rdy = out_ready || (exp_q.size() < ST);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, exp_rdy); end
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_extra_output: got %h want none", result); end
        else if ({negative, zero, result} !== exp_q[0]) begin
          bad++; $display("FAIL rnd_data: got %h want %h", {negative, zero, result}, exp_q[0]);
        end
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_full(op, a, b));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_drain_extra: got %h want none", result); end
        else begin
          logic [DS+1:0] e;
          e = exp_q.pop_front();
          if ({negative, zero, result} !== e) begin bad++; $display("FAIL rnd_drain: got %h want %h", {negative, zero, result}, e); end
        end
      end
      step();
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rnd_lost: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_flags();
    test_back_to_back();
    test_full_swap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, operand and result width in bits (legal 1..64).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in registered stages (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers an operation this cycle.
REQ-006 SHALL have port in_ready  output  1  unit accepts the operation this cycle.
REQ-007 SHALL have port op  input  3  operation select, encoded per the shared package.
REQ-008 SHALL have ports a and b  input  DATA_SIZE  operands.
REQ-009 SHALL have port out_valid  output  1  result present at the output.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-011 SHALL have port result  output  DATA_SIZE  bitwise result.
REQ-012 SHALL have ports zero and negative  output  1 each  flags: result all zeros, and result MSB.

Function
REQ-013 SHALL encode op as: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN (a & ~b), 5 NOT_A, 6 PASS_A, 7 PASS_B.
REQ-014 SHALL compute each result bit i only from a[i], b[i] and op.
REQ-015 SHALL evaluate the operation combinationally before stage 1 and carry only the result and flags through stages 1..STAGES.
REQ-016 SHALL transfer an input when in_valid and in_ready are both high at a clock edge.
REQ-017 SHALL transfer an output when out_valid and out_ready are both high at a clock edge.
REQ-018 SHALL give a latency of exactly STAGES cycles from input transfer to out_valid when out_ready is held high.
REQ-019 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-020 SHALL advance each stage k when stage k is empty or stage k+1 advances; the last stage advances when it is empty or out_ready is high.
REQ-021 SHALL drive in_ready high exactly when stage 1 can advance; in_ready depends on out_ready combinationally and on no other input.
REQ-022 SHALL hold result, zero, negative and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL never drop or duplicate a transfer; with all stages full and out_ready=0, in_ready SHALL be 0.
REQ-024 SHALL, on a simultaneous output transfer and input transfer while the unit is full, accept the new operation in the same edge.
REQ-025 SHALL treat op values as don't-care when in_valid=0.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear all stage valid bits and hold out_valid=0, result=0, zero=0, negative=0.
REQ-027 SHALL drive in_ready=0 while reset_n is low, and drive in_ready=1 from the first edge after reset_n is released.
REQ-028 SHALL discard all in-flight operations when reset is asserted mid-operation; no result from before reset is ever presented.

Configuration
REQ-029 SHALL, with macro BITWISE_LOGIC_FLAGS_EN defined, compute zero and negative and pipeline them alongside result.
REQ-030 SHALL, without BITWISE_LOGIC_FLAGS_EN, tie zero and negative to 0 and omit their flag registers.

Structure
REQ-031 SHALL place the op encoding enum and the stage-count limits in a shared package bitwise_logic_pkg.
REQ-032 SHALL use one sub-module, blu_stage, to hold a single valid/result/flags register with hold control, instantiated STAGES times by a generate loop.

Verification
REQ-033 Verify: after reset, with STAGES=2 and out_ready=1, present op=AND, a=0xFF00_FF00_FF00_FF00, b=0x0F0F_0F0F_0F0F_0F0F -> result=0x0F00_0F00_0F00_0F00, out_valid two cycles after the input transfer, zero=0, negative=0.
REQ-034 Verify: send op=XOR with a=b=0xDEAD_BEEF_0000_1234 -> result=0, zero=1; send op=NOT_A with a=0 -> result=all ones, negative=1.
REQ-035 Verify: issue 8 back-to-back operations with out_ready=0 -> in_ready falls after STAGES are accepted; raising out_ready delivers all 8 results in order, one per cycle, and none are lost.
REQ-036 Verify: with the unit full and out_ready=0, assert in_valid, then raise out_ready for one cycle -> exactly one output transfer and one input transfer occur on the same edge.
REQ-037 Verify: assert reset_n=0 mid-stream with 2 results in flight -> out_valid=0 immediately; after release, no stale result appears.
REQ-038 Verify: build without BITWISE_LOGIC_FLAGS_EN and send op=NOR with a=b=0 -> result=all ones, zero=0, negative=0.
